// File: rtl/xcom_rx_arb_if.sv
// Signal bundle between the xcom link receivers, the rx arbiter and the
// downstream req/ack synchronizer stage.
interface xcom_rx_arb_if #(
    parameter int CH = 2,
    parameter int CW = 4,
    parameter int DW = 32
);
    logic               en_i;
    logic [CH-1:0]      rx_req_i;
    logic [CH-1:0]      rx_ack_o;
    logic [CH*CW-1:0]   rx_cmd_i;
    logic [CH*DW-1:0]   rx_dt_i;
    logic               out_req_o;
    logic               out_ack_i;
    logic [CW-1:0]      out_cmd_o;
    logic [DW-1:0]      out_dt_o;
    logic [3:0]         out_id_o;
    logic [1:0]         arb_st_do;
    logic [15:0]        xfer_cnt_do;

    modport slave (
        input  en_i, rx_req_i, rx_cmd_i, rx_dt_i, out_ack_i,
        output rx_ack_o, out_req_o, out_cmd_o, out_dt_o, out_id_o,
               arb_st_do, xfer_cnt_do
    );

    modport master (
        output en_i, rx_req_i, rx_cmd_i, rx_dt_i, out_ack_i,
        input  rx_ack_o, out_req_o, out_cmd_o, out_dt_o, out_id_o,
               arb_st_do, xfer_cnt_do
    );
endinterface

// File: rtl/xcom_rx_arb.sv
// Round-robin arbiter: picks one of CH four-phase link requests, latches its
// command and forwards it over a single four-phase handshake downstream.
module xcom_rx_arb #(
    parameter int CH = 2,
    parameter int CW = 4,
    parameter int DW = 32
) (
    input  logic          x_clk_i,
    input  logic          x_rst_ni,
    xcom_rx_arb_if.slave  bus
);
    localparam int PW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } st_e;

    st_e             r_st,  w_st;
    logic [PW-1:0]   r_ptr, w_ptr;
    logic [PW-1:0]   r_sel, w_sel;
    logic            r_req, w_req;
    logic [CH-1:0]   r_ack, w_ack;
    logic [CW-1:0]   r_cmd, w_cmd;
    logic [DW-1:0]   r_dt,  w_dt;
    logic [3:0]      r_id,  w_id;
    logic [15:0]     r_cnt, w_cnt;

    logic            w_gnt_vld;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_cand;

    // Scan ptr+1 .. ptr+CH (mod CH); the first requester found wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int i = 1; i <= CH; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(CH))
                w_sum = w_sum - (PW+1)'(CH);
            w_cand = w_sum[PW-1:0];
            if (!w_gnt_vld && bus.rx_req_i[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_st  = r_st;
        w_ptr = r_ptr;
        w_sel = r_sel;
        w_req = r_req;
        w_ack = r_ack;
        w_cmd = r_cmd;
        w_dt  = r_dt;
        w_id  = r_id;
        w_cnt = r_cnt;
        case (r_st)
            ST_IDLE: begin
                // A lingering downstream ack means the previous handshake has
                // not fully returned to zero, so hold off the next grant.
                if (bus.en_i && w_gnt_vld && !bus.out_ack_i) begin
                    w_cmd = bus.rx_cmd_i[w_gnt_idx*CW +: CW];
                    w_dt  = bus.rx_dt_i[w_gnt_idx*DW +: DW];
                    w_id  = '0;
                    w_id[PW-1:0] = w_gnt_idx;
                    w_sel = w_gnt_idx;
                    w_req = 1'b1;
                    w_st  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.out_ack_i) begin
                    w_req        = 1'b0;
                    w_ack        = '0;
                    w_ack[r_sel] = 1'b1;
                    w_st         = ST_REL;
                end
            end
            ST_REL: begin
                if (!bus.out_ack_i && !bus.rx_req_i[r_sel]) begin
                    w_ack = '0;
                    w_ptr = r_sel;
                    w_cnt = r_cnt + 16'd1;
                    w_st  = ST_IDLE;
                end
            end
            default: begin
                w_req = 1'b0;
                w_ack = '0;
                w_st  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
        if (!x_rst_ni) begin
            r_st  <= ST_IDLE;
            r_ptr <= PW'(CH-1);
            r_sel <= '0;
            r_req <= 1'b0;
            r_ack <= '0;
            r_cmd <= '0;
            r_dt  <= '0;
            r_id  <= '0;
            r_cnt <= '0;
        end else begin
            r_st  <= w_st;
            r_ptr <= w_ptr;
            r_sel <= w_sel;
            r_req <= w_req;
            r_ack <= w_ack;
            r_cmd <= w_cmd;
            r_dt  <= w_dt;
            r_id  <= w_id;
            r_cnt <= w_cnt;
        end
    end

    assign bus.rx_ack_o    = r_ack;
    assign bus.out_req_o   = r_req;
    assign bus.out_cmd_o   = r_cmd;
    assign bus.out_dt_o    = r_dt;
    assign bus.out_id_o    = r_id;
    assign bus.arb_st_do   = r_st;
    assign bus.xfer_cnt_do = r_cnt;
endmodule

// File: tb/tb_xcom_rx_arb.sv
// Directed bench for xcom_rx_arb: cycle vector tables plus hand-written
// sequences for enable gating, release ordering, blocked start and reset.
module tb_xcom_rx_arb;
    localparam int CH = 2;
    localparam int CW = 4;
    localparam int DW = 32;
    localparam logic [3:0]  C0 = 4'hA;
    localparam logic [31:0] D0 = 32'h0000A0A0;
    localparam logic [3:0]  C1 = 4'h5;
    localparam logic [31:0] D1 = 32'hDEADBEEF;

    logic clk;
    logic rst_n;

    xcom_rx_arb_if #(.CH(CH), .CW(CW), .DW(DW)) bus ();

    xcom_rx_arb #(.CH(CH), .CW(CW), .DW(DW)) dut (
        .x_clk_i  (clk),
        .x_rst_ni (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [1:0]  req;
        logic        ack;
        logic        e_oreq;
        logic [1:0]  e_ack;
        logic [1:0]  e_st;
        logic [3:0]  e_id;
        logic [3:0]  e_cmd;
        logic [31:0] e_dt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] req, input logic ack);
        bus.en_i      = en;
        bus.rx_req_i  = req;
        bus.out_ack_i = ack;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 1'b0);
        tick();
        chk("rst.out_req", bus.out_req_o, 0);
        chk("rst.rx_ack", bus.rx_ack_o, 0);
        chk("rst.st", bus.arb_st_do, 0);
        chk("rst.cnt", bus.xfer_cnt_do, 0);
        chk("rst.latched", {bus.out_id_o, bus.out_cmd_o, bus.out_dt_o}, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            drive(tv[i].en, tv[i].req, tv[i].ack);
            tick();
            chk($sformatf("%s[%0d].out_req", tag, i), bus.out_req_o, tv[i].e_oreq);
            chk($sformatf("%s[%0d].rx_ack", tag, i), bus.rx_ack_o, tv[i].e_ack);
            chk($sformatf("%s[%0d].st", tag, i), bus.arb_st_do, tv[i].e_st);
            chk($sformatf("%s[%0d].id", tag, i), bus.out_id_o, tv[i].e_id);
            chk($sformatf("%s[%0d].cmd", tag, i), bus.out_cmd_o, tv[i].e_cmd);
            chk($sformatf("%s[%0d].dt", tag, i), bus.out_dt_o, tv[i].e_dt);
            chk($sformatf("%s[%0d].cnt", tag, i), bus.xfer_cnt_do, tv[i].e_cnt);
        end
    endtask

    // Handshake outputs and state after one edge.
    task automatic chk_hs(input string nm, input logic oreq, input logic [1:0] ack,
                          input logic [1:0] st);
        chk({nm, ".out_req"}, bus.out_req_o, oreq);
        chk({nm, ".rx_ack"}, bus.rx_ack_o, ack);
        chk({nm, ".st"}, bus.arb_st_do, st);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rx_cmd_i = {C1, C0};
        bus.rx_dt_i  = {D1, D0};
        drive(1'b0, 2'b00, 1'b0);

        // Single request from link 1; rows 0..5.
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 2'd1, 4'd1, C1, D1, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 2'd1, 4'd1, C1, D1, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 2'd1, 4'd1, C1, D1, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 2'd2, 4'd1, C1, D1, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd2, 4'd1, C1, D1, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'd0, 4'd1, C1, D1, 16'd1});
        // Round-robin, both links re-request right after release; rows 6..17.
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 4'd0, C0, D0, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'd2, 4'd0, C0, D0, 16'd0});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'd0, 4'd0, C0, D0, 16'd1});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 4'd1, C1, D1, 16'd1});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 2'd2, 4'd1, C1, D1, 16'd1});
        tv.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'd0, 4'd1, C1, D1, 16'd2});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 4'd0, C0, D0, 16'd2});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'd2, 4'd0, C0, D0, 16'd2});
        tv.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'd0, 4'd0, C0, D0, 16'd3});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 4'd1, C1, D1, 16'd3});
        tv.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 2'd2, 4'd1, C1, D1, 16'd3});
        tv.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'd0, 4'd1, C1, D1, 16'd4});

        tick();
        do_reset();
        run_rows(0, 6, "single");
        do_reset();
        run_rows(6, 18, "rr");

        // Enable gate, including en_i dropped mid-transfer.
        do_reset();
        drive(1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_hs($sformatf("engate.off%0d", i), 1'b0, 2'b00, 2'd0);
        end
        bus.en_i = 1'b1;
        tick();
        chk_hs("engate.on", 1'b1, 2'b00, 2'd1);
        chk("engate.id", bus.out_id_o, 0);
        drive(1'b0, 2'b01, 1'b1);
        tick();
        chk_hs("engate.midxfer", 1'b0, 2'b01, 2'd2);
        drive(1'b0, 2'b00, 1'b0);
        tick();
        chk_hs("engate.done", 1'b0, 2'b00, 2'd0);
        chk("engate.cnt1", bus.xfer_cnt_do, 1);
        drive(1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hs($sformatf("engate.hold%0d", i), 1'b0, 2'b00, 2'd0);
        end
        bus.en_i = 1'b1;
        tick();
        chk_hs("engate.regrant", 1'b1, 2'b00, 2'd1);
        drive(1'b1, 2'b01, 1'b1);
        tick();
        drive(1'b1, 2'b00, 1'b0);
        tick();
        chk("engate.cnt2", bus.xfer_cnt_do, 2);

        // Link 1 drops its request while in REQ: transfer still completes.
        drive(1'b1, 2'b10, 1'b0);
        tick();
        chk_hs("viol.grant", 1'b1, 2'b00, 2'd1);
        chk("viol.id", bus.out_id_o, 1);
        drive(1'b1, 2'b00, 1'b0);
        tick();
        chk_hs("viol.hold", 1'b1, 2'b00, 2'd1);
        drive(1'b1, 2'b00, 1'b1);
        tick();
        chk_hs("viol.rel", 1'b0, 2'b10, 2'd2);
        drive(1'b1, 2'b00, 1'b0);
        tick();
        chk_hs("viol.done", 1'b0, 2'b00, 2'd0);
        chk("viol.cnt", bus.xfer_cnt_do, 3);

        // Release ordering: downstream ack falls well before the link's req.
        drive(1'b1, 2'b01, 1'b0);
        tick();
        chk("relord.id", bus.out_id_o, 0);
        drive(1'b1, 2'b01, 1'b1);
        tick();
        chk_hs("relord.rel", 1'b0, 2'b01, 2'd2);
        bus.out_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_hs($sformatf("relord.wait%0d", i), 1'b0, 2'b01, 2'd2);
        end
        bus.rx_req_i = 2'b00;
        tick();
        chk_hs("relord.idle", 1'b0, 2'b00, 2'd0);
        chk("relord.cnt", bus.xfer_cnt_do, 4);

        // Blocked start: stale downstream ack prevents a grant.
        drive(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_hs($sformatf("blocked.%0d", i), 1'b0, 2'b00, 2'd0);
        end
        bus.out_ack_i = 1'b0;
        tick();
        chk_hs("blocked.grant", 1'b1, 2'b00, 2'd1);
        drive(1'b1, 2'b01, 1'b1);
        tick();
        drive(1'b1, 2'b00, 1'b0);
        tick();
        chk("blocked.cnt", bus.xfer_cnt_do, 5);

        // Reset mid-REL with pointer at link 0: outputs drop without an edge,
        // and link 0 must still win first after reset.
        drive(1'b1, 2'b01, 1'b0);
        tick();
        drive(1'b1, 2'b01, 1'b1);
        tick();
        chk_hs("rstrel.rel", 1'b0, 2'b01, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_hs("rstrel.async", 1'b0, 2'b00, 2'd0);
        chk("rstrel.cnt", bus.xfer_cnt_do, 0);
        drive(1'b1, 2'b11, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk_hs("rstrel.grant", 1'b1, 2'b00, 2'd1);
        chk("rstrel.id", bus.out_id_o, 0);
        chk("rstrel.cmd", bus.out_cmd_o, C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/xcom_rx_arb.md
Name: xcom_rx_arb

Overview:
- Round-robin arbiter that shares one command path among CH xcom link receivers.
- Each link presents a command/data word over a four-phase req/ack handshake. The arbiter grants one link at a time and latches its command into a holding register.
- It then drives a single four-phase req/ack toward the clock-domain-crossing stage feeding the core-side command decoder.
- Lives in the xcom clock domain, between the link receivers and the req/ack synchronizers.

Parameters:
- CH, 2, number of link receivers (1..8).
- CW, 4, command opcode width.
- DW, 32, command data width.

Ports:
- x_clk_i  in  1  xcom clock
- x_rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  arbitration enable; low blocks new grants only
- rx_req_i  in  CH  per-link request
- rx_ack_o  out  CH  per-link acknowledge (one-hot or zero)
- rx_cmd_i  in  CH*CW  per-link opcode, link k at bits [k*CW +: CW]
- rx_dt_i  in  CH*DW  per-link data, link k at bits [k*DW +: DW]
- out_req_o  out  1  downstream request
- out_ack_i  in  1  downstream acknowledge (already synchronized)
- out_cmd_o  out  CW  latched opcode
- out_dt_o  out  DW  latched data
- out_id_o  out  4  latched link index, zero-extended
- arb_st_do  out  2  debug FSM state: IDLE=0, REQ=1, REL=2
- xfer_cnt_do  out  16  debug count of completed transfers

Behaviour:
- Reset: asynchronous, active-low. All outputs and registers are 0 on reset, except the RR pointer ptr, which is CH-1 so link 0 has first priority.
- Outputs: all registered, no combinational input-to-output paths.
- Grant selection, combinational over rx_req_i:
  - first k in the order ptr+1, ptr+2, ..., ptr+CH (mod CH) with rx_req_i[k]=1;
  - the computed index is k, not ptr.
- FSM states: IDLE, REQ, REL.
- IDLE:
  - Grant condition: en_i=1, any rx_req_i=1, and out_ack_i=0.
  - When it holds, latch in one cycle: out_cmd_o, out_dt_o and out_id_o from link k; sel<=k; out_req_o<=1; go to REQ.
  - If the condition is false, stay in IDLE.
- REQ:
  - Hold out_req_o=1 with latched outputs stable.
  - On out_ack_i=1: out_req_o<=0, rx_ack_o[sel]<=1, go to REL.
- REL:
  - Hold rx_ack_o[sel]=1.
  - When out_ack_i=0 and rx_req_i[sel]=0 are both true in the same cycle: rx_ack_o<=0, ptr<=sel, xfer_cnt_do<=xfer_cnt_do+1, go to IDLE.
- Latency:
  - rx_req_i high at edge N gives out_req_o high after edge N+1.
  - out_ack_i high at edge M gives rx_ack_o high and out_req_o low after edge M+1.
- Minimum spacing: one IDLE cycle between consecutive grants.
- Latched outputs: out_cmd_o, out_dt_o and out_id_o change only on a grant. Between transfers they hold the last granted value.
- Simultaneous requests: resolved purely by RR order. A link just served has lowest priority on the next grant.
- rx_req_i drops while in REQ (protocol violation): ignored; the transfer completes.
- en_i deasserted mid-transfer: the current transfer completes; no new grant until en_i=1.
- out_ack_i high while in IDLE: no grant until it falls.
- xfer_cnt_do: wraps 0xFFFF -> 0x0000.
- Reset mid-transfer: all handshake outputs drop immediately, the FSM returns to IDLE, and ptr=CH-1. Upstream links must tolerate the ack loss.
- CH=1: ptr is constant 0 and grant order is trivially link 0.

Test Plan:
- Single request: link 1 asserts with cmd=0x5, dt=0xDEADBEEF; downstream acks 3 cycles after out_req_o. Required:
  - out_req_o rises 1 cycle after the request;
  - out_cmd_o=0x5, out_dt_o=0xDEADBEEF, out_id_o=1;
  - rx_ack_o=2'b10 one cycle after out_ack_i;
  - after both release, xfer_cnt_do=1.
- Round-robin: links 0 and 1 request continuously for 4 transfers from reset. Required: grant order 0,1,0,1 with xfer_cnt_do=4.
- Enable gate: en_i=0 while link 0 requests for 10 cycles. Required: out_req_o stays 0. Then raise en_i; required: out_req_o rises 1 cycle later.
- Release ordering: in REL, out_ack_i falls 5 cycles before rx_req_i[sel]. Required: rx_ack_o holds high until rx_req_i falls; FSM returns to IDLE the next cycle.
- Blocked start: out_ack_i held high while link 0 requests. Required: no grant; the grant occurs 1 cycle after out_ack_i falls.
- Reset mid-REL: assert x_rst_ni=0 asynchronously. Required:
  - rx_ack_o=0, out_req_o=0 and arb_st_do=0 without waiting for a clock edge;
  - after release with both links requesting, link 0 is granted first.
